ovf_status_queue: RTL
=====================

Name: ovf_status_queue

Overview:
- Sequential successor to the combinational overflow-status decoder.
- Decodes the execute-stage instruction into an rstatus code (add=1, addi=2, sub=3, mul=4, div=5) and qualifies it with the actual overflow/exception flag.
- Tracks one in-flight multicycle mul/div until it completes, and queues pending status codes in a FIFO.
- Drains codes to the writeback arbiter over a valid/ready handshake, which writes them to $r30 (rstatus); also maintains a saturating overflow counter and a sticky lost-event flag.

Parameters:
- STATUS_W, 32, width of a status code / st_data.
- FIFO_DEPTH, 4, pending-code entries; power of two, >=2.
- CNT_W, 8, width of the saturating overflow counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- ex_valid  in  1  execute-stage instruction valid this cycle.
- ex_op  in  5  opcode.
- ex_alu_op  in  5  ALU op field (meaningful only when ex_op==0).
- ex_ovf  in  1  ALU overflow for add/addi/sub this cycle.
- md_ready  in  1  multdiv result ready (one-cycle pulse).
- md_exception  in  1  multdiv exception; valid with md_ready.
- flush  in  1  cancel the in-flight mul/div; FIFO untouched.
- st_valid  out  1  head code available.
- st_data  out  STATUS_W  head code, zero-extended.
- st_ready  in  1  arbiter accepts head.
- pending_cnt  out  $clog2(FIFO_DEPTH)+1  FIFO occupancy.
- ovf_count  out  CNT_W  saturating count of queued codes.
- lost  out  1  sticky; a code was dropped because the FIFO was full.
- clr_count  in  1  clears ovf_count and lost.

Behaviour:
- Decode (combinational):
  - R-type: ex_op==5'b00000.
  - add: R-type & alu_op 00000. sub: R-type & alu_op 00001. mul: R-type & alu_op 00110. div: R-type & alu_op 00111.
  - addi: ex_op==5'b00101.
  - Any other encoding produces no event.
- Reset (reset==0, async):
  - FIFO empty: st_valid=0, st_data=0, pending_cnt=0.
  - ovf_count=0, lost=0, md FSM in IDLE.
- ALU event: ex_valid & (add|addi|sub) & ex_ovf pushes code 1, 2 or 3. Latency: st_valid rises the cycle after the push edge when the FIFO was empty; there is no bypass.
- md FSM:
  - IDLE: on ex_valid & (mul|div), latch code (4 or 5) and go to BUSY.
  - BUSY, md_ready=1: push the latched code if md_exception=1, then go to IDLE. If an ex_valid mul/div arrives in the same cycle, latch the new code and stay in BUSY.
  - BUSY, flush=1 (priority over md_ready): go to IDLE, no push.
  - BUSY, new ex_valid mul/div without md_ready: overwrite the latched code and stay in BUSY (the restarted op supersedes).
  - md_ready while IDLE is ignored.
- Simultaneous pushes: the md completion is older, so it is written first and the ALU code is written at the next slot. Up to 2 pushes per cycle.
- Pop: st_valid & st_ready removes the head.
  - Push and pop in the same cycle is allowed.
  - Space check uses occupancy after that cycle's pop.
- Full: a push with no space drops that code (the second code drops first when only one slot is free) and sets lost=1.
- ovf_count: increments by the number of codes accepted into the FIFO (0..2) and saturates at 2^CNT_W-1.
- clr_count: zeroes ovf_count and lost next edge; clear wins over a same-cycle increment.
- Pointers wrap modulo FIFO_DEPTH.
- Outputs are registered or driven from FIFO state only; there is no combinational path from st_ready to st_valid.

Decomposition:
- Package ovf_status_pkg:
  - opcode constants OP_RTYPE=5'b00000, OP_ADDI=5'b00101.
  - ALU-op constants ALU_ADD/SUB/MUL/DIV.
  - status codes ST_ADD=1, ST_ADDI=2, ST_SUB=3, ST_MUL=4, ST_DIV=5.
  - md FSM state enum {MD_IDLE, MD_BUSY}.
- Sub-module status_fifo: parametrised depth/width, dual-write-port, single-read FIFO with occupancy output and accept count. Top level holds the decode, the md FSM and the counter.

Test Plan:
- Reset then add with ex_ovf=1, st_ready=0 -> next cycle st_valid=1, st_data=1, pending_cnt=1, ovf_count=1. Drive st_ready=1 -> st_valid=0 the following cycle.
- addi, then sub, both with ovf=1, st_ready=0 -> FIFO holds 2 then 3 in order. Add with ovf=0 -> no push.
- mul issued, md_ready+md_exception 5 cycles later, same cycle as an ALU sub overflow -> queue order 4, 3; pending_cnt=2; ovf_count=2.
- div issued, then flush, then md_ready+md_exception -> nothing queued, FSM IDLE. Div issued, md_ready with md_exception=0 -> nothing queued.
- FIFO_DEPTH=4, st_ready=0, 5 add overflows -> pending_cnt=4, lost=1, ovf_count=4. Then a pop and a push in the same cycle -> pending_cnt stays 4.
- CNT_W=2, 4 accepted overflows -> ovf_count=3 (saturated). clr_count -> 0 and lost=0. Assert reset mid-BUSY with a full FIFO -> all outputs zero immediately (async).

Source files
------------

// File: rtl/ovf_status_pkg.sv
// Shared constants, state encoding and instruction decode for ovf_status_queue.
// Latency: none (combinational helpers only).
// Backpressure: not applicable.
package ovf_status_pkg;

  // Opcode field encodings
  localparam logic [4:0] OP_RTYPE = 5'b00000;
  localparam logic [4:0] OP_ADDI  = 5'b00101;

  // ALU-op field encodings (meaningful for R-type only)
  localparam logic [4:0] ALU_ADD = 5'b00000;
  localparam logic [4:0] ALU_SUB = 5'b00001;
  localparam logic [4:0] ALU_MUL = 5'b00110;
  localparam logic [4:0] ALU_DIV = 5'b00111;

  // rstatus codes; all fit in three bits and are zero-extended on the way out
  localparam int         CODE_W  = 3;
  localparam logic [2:0] ST_NONE = 3'd0;
  localparam logic [2:0] ST_ADD  = 3'd1;
  localparam logic [2:0] ST_ADDI = 3'd2;
  localparam logic [2:0] ST_SUB  = 3'd3;
  localparam logic [2:0] ST_MUL  = 3'd4;
  localparam logic [2:0] ST_DIV  = 3'd5;

  typedef enum logic {
    MD_IDLE = 1'b0,
    MD_BUSY = 1'b1
  } md_state_e;

  // One-hot-or-zero decode of the execute-stage instruction
  typedef struct packed {
    logic add;
    logic addi;
    logic sub;
    logic mul;
    logic div;
  } dec_t;

  function automatic dec_t decode(input logic [4:0] op, input logic [4:0] alu_op);
    dec_t d;
    logic rtype;
    rtype  = (op == OP_RTYPE);
    d.add  = rtype && (alu_op == ALU_ADD);
    d.sub  = rtype && (alu_op == ALU_SUB);
    d.mul  = rtype && (alu_op == ALU_MUL);
    d.div  = rtype && (alu_op == ALU_DIV);
    d.addi = (op == OP_ADDI);
    return d;
  endfunction

  // Status code for the single-cycle ALU class; ST_NONE when not an ALU op
  function automatic logic [2:0] alu_code(input dec_t d);
    logic [2:0] c;
    c = ST_NONE;
    if (d.add)       c = ST_ADD;
    else if (d.addi) c = ST_ADDI;
    else if (d.sub)  c = ST_SUB;
    return c;
  endfunction

endpackage

// File: rtl/status_fifo.sv
// Generic FIFO with two ordered write ports (wr0 older than wr1) and one read port.
// Latency: a written entry is visible on rd_vld_o the cycle after the write edge (no bypass).
// Backpressure: free space is judged after this cycle's pop; wr1 is dropped before wr0.
//
// Ports:
//   clk_i, rst_ni            clock, async active-low reset
//   wr0_vld_i/wr0_dat_i      older write request
//   wr1_vld_i/wr1_dat_i      younger write request
//   rd_vld_o/rd_dat_o        head entry (data forced to zero when empty)
//   rd_rdy_i                 consumer takes the head
//   occ_o                    current occupancy
//   acc_cnt_o                writes accepted this cycle (0..2)
//   drop_o                   at least one write rejected this cycle
module status_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     wr0_vld_i,
  input  logic [W-1:0]             wr0_dat_i,
  input  logic                     wr1_vld_i,
  input  logic [W-1:0]             wr1_dat_i,
  output logic                     rd_vld_o,
  output logic [W-1:0]             rd_dat_o,
  input  logic                     rd_rdy_i,
  output logic [$clog2(DEPTH):0]   occ_o,
  output logic [1:0]               acc_cnt_o,
  output logic                     drop_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic             pop;
  logic [CW-1:0]    free;
  logic             acc0, acc1;
  logic [1:0]       n_acc;
  logic [W-1:0]     first_dat;
  logic [PTR_W-1:0] slot1;

  always_comb begin
    pop   = (cnt_q != '0) && rd_rdy_i;
    // A same-cycle pop frees a slot for this cycle's writes
    free  = CW'(DEPTH) - cnt_q + CW'(pop);
    acc0  = wr0_vld_i && (free != '0);
    acc1  = wr1_vld_i && (free >= (acc0 ? CW'(2) : CW'(1)));
    n_acc = {acc0 & acc1, acc0 ^ acc1};
    // Accepted writes are packed: whichever lands first takes wr_ptr
    first_dat = acc0 ? wr0_dat_i : wr1_dat_i;
    slot1     = wr_ptr_q + 1'b1;
    cnt_d     = cnt_q + CW'(n_acc) - CW'(pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(n_acc);
    rd_ptr_d  = rd_ptr_q + PTR_W'(pop);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      cnt_q    <= cnt_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset: the read side is masked while empty
  always_ff @(posedge clk_i) begin
    if (acc0 || acc1) mem_q[wr_ptr_q] <= first_dat;
    if (acc0 && acc1) mem_q[slot1]    <= wr1_dat_i;
  end

  assign rd_vld_o  = (cnt_q != '0);
  assign rd_dat_o  = rd_vld_o ? mem_q[rd_ptr_q] : '0;
  assign occ_o     = cnt_q;
  assign acc_cnt_o = n_acc;
  assign drop_o    = (wr0_vld_i && !acc0) || (wr1_vld_i && !acc1);

endmodule

// File: rtl/ovf_status_queue.sv
// Overflow/exception status queue: decodes EX instructions, tracks one in-flight mul/div,
// queues rstatus codes for the writeback arbiter. Latency: code visible one cycle after push.
// Backpressure: st_valid/st_ready handshake; codes arriving to a full queue are dropped and flagged.
//
// Ports:
//   clock, reset              clock, async active-low reset
//   ex_valid/ex_op/ex_alu_op  execute-stage instruction
//   ex_ovf                    ALU overflow for add/addi/sub
//   md_ready/md_exception     multdiv completion pulse and its exception flag
//   flush                     cancel in-flight mul/div
//   st_valid/st_data/st_ready head of pending-code queue toward writeback
//   pending_cnt               queue occupancy
//   ovf_count/lost/clr_count  saturating accepted-code count, sticky drop flag, clear
module ovf_status_queue
  import ovf_status_pkg::*;
#(
  parameter int STATUS_W   = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          ex_valid,
  input  logic [4:0]                    ex_op,
  input  logic [4:0]                    ex_alu_op,
  input  logic                          ex_ovf,
  input  logic                          md_ready,
  input  logic                          md_exception,
  input  logic                          flush,
  output logic                          st_valid,
  output logic [STATUS_W-1:0]           st_data,
  input  logic                          st_ready,
  output logic [$clog2(FIFO_DEPTH):0]   pending_cnt,
  output logic [CNT_W-1:0]              ovf_count,
  output logic                          lost,
  input  logic                          clr_count
);

  dec_t        dec;
  logic        alu_push;
  logic [2:0]  alu_st;
  logic        md_issue;
  logic [2:0]  md_new_code;
  logic        md_push;

  md_state_e   md_state_q;
  logic [2:0]  md_code_q;

  logic [1:0]  acc_cnt;
  logic        drop;

  logic [CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;
  logic             lost_q, lost_d;
  logic [CNT_W:0]   cnt_sum;

  always_comb begin
    dec         = decode(ex_op, ex_alu_op);
    alu_st      = alu_code(dec);
    alu_push    = ex_valid && (dec.add || dec.addi || dec.sub) && ex_ovf;
    md_issue    = ex_valid && (dec.mul || dec.div);
    md_new_code = dec.div ? ST_DIV : ST_MUL;
    // Flush outranks a same-cycle completion
    md_push     = (md_state_q == MD_BUSY) && md_ready && md_exception && !flush;
  end

  // Multicycle tracker: only the most recently issued mul/div is of interest
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      md_state_q <= MD_IDLE;
      md_code_q  <= ST_NONE;
    end else begin
      case (md_state_q)
        MD_IDLE: begin
          if (md_issue) begin
            md_state_q <= MD_BUSY;
            md_code_q  <= md_new_code;
          end
        end
        MD_BUSY: begin
          if (flush) begin
            md_state_q <= MD_IDLE;
          end else if (md_ready) begin
            // Completion handled via md_push; a back-to-back issue keeps us busy
            if (md_issue) begin
              md_code_q <= md_new_code;
            end else begin
              md_state_q <= MD_IDLE;
            end
          end else if (md_issue) begin
            md_code_q <= md_new_code;
          end
        end
        default: md_state_q <= MD_IDLE;
      endcase
    end
  end

  // The md completion is the older event, so it owns the first write port
  status_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (STATUS_W)
  ) u_fifo (
    .clk_i     (clock),
    .rst_ni    (reset),
    .wr0_vld_i (md_push),
    .wr0_dat_i (STATUS_W'(md_code_q)),
    .wr1_vld_i (alu_push),
    .wr1_dat_i (STATUS_W'(alu_st)),
    .rd_vld_o  (st_valid),
    .rd_dat_o  (st_data),
    .rd_rdy_i  (st_ready),
    .occ_o     (pending_cnt),
    .acc_cnt_o (acc_cnt),
    .drop_o    (drop)
  );

  always_comb begin
    cnt_sum = {1'b0, ovf_cnt_q} + (CNT_W+1)'(acc_cnt);
    if (cnt_sum > {1'b0, {CNT_W{1'b1}}}) ovf_cnt_d = {CNT_W{1'b1}};
    else                                 ovf_cnt_d = cnt_sum[CNT_W-1:0];
    lost_d = lost_q || drop;
    // Clear beats any same-cycle increment or drop
    if (clr_count) begin
      ovf_cnt_d = '0;
      lost_d    = 1'b0;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovf_cnt_q <= '0;
      lost_q    <= 1'b0;
    end else begin
      ovf_cnt_q <= ovf_cnt_d;
      lost_q    <= lost_d;
    end
  end

  assign ovf_count = ovf_cnt_q;
  assign lost      = lost_q;

endmodule
